// File: rtl/tlb_cam_pkg.sv
// Shared encodings for the tlb_cam translation store.
package tlb_cam_pkg;

  localparam int unsigned CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 2'b00,
    CMD_INS = 2'b01,
    CMD_DEL = 2'b10,
    CMD_RD  = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/tlb_cam_if.sv
// Command/response bundle between the requester (master) and tlb_cam (slave).
interface tlb_cam_if
  import tlb_cam_pkg::*;
#(
  parameter int unsigned KEY_W  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  cmd_e              cmd;
  logic [KEY_W-1:0]  key;
  logic [DATA_W-1:0] datain;
  logic              rsp_valid;
  logic              rsp_hit;
  logic              rsp_fault;
  logic              rsp_full;
  logic [IDX_W-1:0]  rsp_idx;
  logic [DATA_W-1:0] dataout;
  logic [IDX_W:0]    occupancy;

  modport master (
    output cmd_valid, cmd, key, datain,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_fault, rsp_full, rsp_idx, dataout, occupancy
  );

  modport slave (
    input  cmd_valid, cmd, key, datain,
    output cmd_ready, rsp_valid, rsp_hit, rsp_fault, rsp_full, rsp_idx, dataout, occupancy
  );
endinterface

// File: rtl/tlb_cam_penc.sv
// Lowest-index priority encoder: found_c set if any bit of vec is high.
module tlb_cam_penc #(
  parameter int unsigned N     = 32,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic             found_c,
  output logic [IDX_W-1:0] idx_c
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found_c = 1'b1;
        idx_c   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_cam.sv
// Fully-associative key->data CAM with a 3-cycle IDLE/LOOKUP/RESP command flow.
// Optional macro TLB_CAM_LRU_EN: age-based LRU replacement when the table is full.
module tlb_cam
  import tlb_cam_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned KEY_W  = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     rst_n,
  tlb_cam_if.slave bus
);

  localparam int unsigned OCC_W = IDX_W + 1;

  state_e            state, state_nxt;
  cmd_e              cmd_q;
  logic [KEY_W-1:0]  key_q;
  logic [DATA_W-1:0] data_q;
  logic [DEPTH-1:0]  valid;
  logic [KEY_W-1:0]  keys [DEPTH];
  logic [DATA_W-1:0] data [DEPTH];
  logic [OCC_W-1:0]  occ;

  logic [DEPTH-1:0]  match_c;
  logic              hit_c, free_c;
  logic [IDX_W-1:0]  hit_idx_c, free_idx_c;

  logic              wr_c, new_c, del_c, touch_c, ins_free_c, occ_inc_c, occ_dec_c;
  logic [IDX_W-1:0]  wr_idx_c, touch_idx_c;
  logic              r_hit_c, r_fault_c, r_full_c;
  logic [IDX_W-1:0]  r_idx_c;
  logic [DATA_W-1:0] r_data_c;

  // Parallel compare of the latched key against every valid entry.
  always_comb begin
    match_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      match_c[i] = valid[i] && (keys[i] == key_q);
    end
  end

  tlb_cam_penc #(.N(DEPTH), .IDX_W(IDX_W)) u_match_enc (
    .vec(match_c), .found_c(hit_c), .idx_c(hit_idx_c)
  );

  tlb_cam_penc #(.N(DEPTH), .IDX_W(IDX_W)) u_free_enc (
    .vec(~valid), .found_c(free_c), .idx_c(free_idx_c)
  );

`ifdef TLB_CAM_LRU_EN
  logic [IDX_W-1:0] age [DEPTH];
  logic [IDX_W-1:0] victim_c;

  // Oldest entry (age DEPTH-1) is the eviction victim when the table is full.
  always_comb begin
    victim_c = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (age[i] == IDX_W'(DEPTH - 1)) victim_c = IDX_W'(i);
    end
  end

  // Keep valid ages a permutation of 0..occupancy-1; age 0 is most recent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < int'(DEPTH); j++) age[j] <= '0;
    end else begin
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (touch_c) begin
          if (IDX_W'(j) == touch_idx_c) age[j] <= '0;
          else if (valid[j] && (age[j] < age[touch_idx_c])) age[j] <= age[j] + IDX_W'(1);
        end else if (ins_free_c) begin
          if (IDX_W'(j) == wr_idx_c) age[j] <= '0;
          else if (valid[j]) age[j] <= age[j] + IDX_W'(1);
        end else if (del_c) begin
          if (valid[j] && (age[j] > age[hit_idx_c])) age[j] <= age[j] - IDX_W'(1);
        end
      end
    end
  end
`else
  logic unused_lru;
  assign unused_lru = ^{touch_c, ins_free_c, touch_idx_c};
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.cmd_valid && bus.cmd_ready) state_nxt = LOOKUP;
      LOOKUP:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command decode during LOOKUP: storage actions and response values.
  always_comb begin
    wr_c = 1'b0; new_c = 1'b0; del_c = 1'b0; wr_idx_c = '0;
    touch_c = 1'b0; touch_idx_c = '0; ins_free_c = 1'b0;
    occ_inc_c = 1'b0; occ_dec_c = 1'b0;
    r_hit_c = 1'b0; r_fault_c = 1'b0; r_full_c = 1'b0; r_idx_c = '0; r_data_c = '0;
    if (state == LOOKUP) begin
      case (cmd_q)
        CMD_INS: begin
          if (hit_c) begin
            wr_c = 1'b1; wr_idx_c = hit_idx_c; r_hit_c = 1'b1; r_idx_c = hit_idx_c;
            touch_c = 1'b1; touch_idx_c = hit_idx_c;
          end else if (free_c) begin
            wr_c = 1'b1; new_c = 1'b1; wr_idx_c = free_idx_c; r_idx_c = free_idx_c;
            occ_inc_c = 1'b1; ins_free_c = 1'b1;
          end else begin
`ifdef TLB_CAM_LRU_EN
            wr_c = 1'b1; new_c = 1'b1; wr_idx_c = victim_c; r_idx_c = victim_c;
            touch_c = 1'b1; touch_idx_c = victim_c;
`else
            r_full_c = 1'b1;
`endif
          end
        end
        CMD_DEL: begin
          if (hit_c) begin
            del_c = 1'b1; occ_dec_c = 1'b1; r_hit_c = 1'b1; r_idx_c = hit_idx_c;
          end
        end
        CMD_RD: begin
          if (hit_c) begin
            r_hit_c = 1'b1; r_idx_c = hit_idx_c; r_data_c = data[hit_idx_c];
            touch_c = 1'b1; touch_idx_c = hit_idx_c;
          end else begin
            r_fault_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Latch the command at the handshake; cmd_ready tracks the IDLE state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= CMD_NOP; key_q <= '0; data_q <= '0; bus.cmd_ready <= 1'b1;
    end else begin
      bus.cmd_ready <= (state_nxt == IDLE);
      if (bus.cmd_valid && bus.cmd_ready && (state == IDLE)) begin
        cmd_q <= bus.cmd; key_q <= bus.key; data_q <= bus.datain;
      end
    end
  end

  // Entry storage and occupancy, updated at the end of LOOKUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0; occ <= '0;
      for (int j = 0; j < int'(DEPTH); j++) begin
        keys[j] <= '0; data[j] <= '0;
      end
    end else begin
      if (wr_c) begin
        data[wr_idx_c] <= data_q;
        if (new_c) begin
          keys[wr_idx_c]  <= key_q;
          valid[wr_idx_c] <= 1'b1;
        end
      end
      if (del_c) valid[hit_idx_c] <= 1'b0;
      if (occ_inc_c)      occ <= occ + OCC_W'(1);
      else if (occ_dec_c) occ <= occ - OCC_W'(1);
    end
  end

  // Response registers: loaded at the end of LOOKUP, zero in every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp_valid <= 1'b0; bus.rsp_hit <= 1'b0; bus.rsp_fault <= 1'b0;
      bus.rsp_full <= 1'b0; bus.rsp_idx <= '0; bus.dataout <= '0;
    end else begin
      bus.rsp_valid <= (state == LOOKUP);
      bus.rsp_hit   <= r_hit_c;
      bus.rsp_fault <= r_fault_c;
      bus.rsp_full  <= r_full_c;
      bus.rsp_idx   <= r_idx_c;
      bus.dataout   <= r_data_c;
    end
  end

  assign bus.occupancy = occ;

endmodule

// File: tb/tb_tlb_cam.sv
// Directed self-checking bench for tlb_cam (DEPTH=4). Define TLB_CAM_LRU_EN for both RTL and bench
// to exercise the LRU replacement variant.
module tb_tlb_cam;
  import tlb_cam_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  tlb_cam_if #(.KEY_W(8), .DATA_W(8), .IDX_W(2)) bus ();

  tlb_cam #(.DEPTH(4), .KEY_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue one command and check handshake timing plus every response field.
  task automatic run(input string tag, input cmd_e c, input logic [7:0] k, input logic [7:0] d,
                     input logic e_hit, input logic e_fault, input logic e_full,
                     input logic [1:0] e_idx, input logic [7:0] e_data, input logic [2:0] e_occ);
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1; bus.cmd = c; bus.key = k; bus.datain = d;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0; bus.cmd = CMD_DEL; bus.key = ~k; bus.datain = ~d;
    @(negedge clk);
    check({tag, "_lookup_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_lookup_valid"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_resp_ready"}, 32'(bus.cmd_ready), 32'd0);
    check({tag, "_hit"}, 32'(bus.rsp_hit), 32'(e_hit));
    check({tag, "_fault"}, 32'(bus.rsp_fault), 32'(e_fault));
    check({tag, "_full"}, 32'(bus.rsp_full), 32'(e_full));
    check({tag, "_idx"}, 32'(bus.rsp_idx), 32'(e_idx));
    check({tag, "_data"}, 32'(bus.dataout), 32'(e_data));
    check({tag, "_occ"}, 32'(bus.occupancy), 32'(e_occ));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_zero_after"}, 32'({bus.rsp_hit, bus.rsp_fault, bus.rsp_full, bus.rsp_idx, bus.dataout}), 32'd0);
  endtask

  task automatic fill4();
    run("fill1", CMD_INS, 8'd1, 8'h11, 0, 0, 0, 2'd0, 8'h00, 3'd1);
    run("fill2", CMD_INS, 8'd2, 8'h22, 0, 0, 0, 2'd1, 8'h00, 3'd2);
    run("fill3", CMD_INS, 8'd3, 8'h33, 0, 0, 0, 2'd2, 8'h00, 3'd3);
    run("fill4", CMD_INS, 8'd4, 8'h44, 0, 0, 0, 2'd3, 8'h00, 3'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = CMD_NOP; bus.key = '0; bus.datain = '0;
    do_reset();

    // 1: reset state and a lookup in an empty table.
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    check("rst_data", 32'(bus.dataout), 32'd0);
    run("t1_rd", CMD_RD, 8'h10, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd0);

    // 2: insert, read, overwrite, read.
    run("t2_ins", CMD_INS, 8'h10, 8'hA5, 0, 0, 0, 2'd0, 8'h00, 3'd1);
    run("t2_rd",  CMD_RD,  8'h10, 8'h00, 1, 0, 0, 2'd0, 8'hA5, 3'd1);
    run("t2_ovw", CMD_INS, 8'h10, 8'h5A, 1, 0, 0, 2'd0, 8'h00, 3'd1);
    run("t2_rd2", CMD_RD,  8'h10, 8'h00, 1, 0, 0, 2'd0, 8'h5A, 3'd1);
    run("t2_nop", CMD_NOP, 8'h10, 8'h00, 0, 0, 0, 2'd0, 8'h00, 3'd1);

    // 3: insert into a full table.
    do_reset();
    fill4();
`ifdef TLB_CAM_LRU_EN
    run("t3_ins5", CMD_INS, 8'd5, 8'h55, 0, 0, 0, 2'd0, 8'h00, 3'd4);
    run("t3_rd1",  CMD_RD,  8'd1, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd4);
    run("t3_rd5",  CMD_RD,  8'd5, 8'h00, 1, 0, 0, 2'd0, 8'h55, 3'd4);

    // 4: a recent read protects key 1, so key 2 is evicted.
    do_reset();
    fill4();
    run("t4_rd1",  CMD_RD,  8'd1, 8'h00, 1, 0, 0, 2'd0, 8'h11, 3'd4);
    run("t4_ins5", CMD_INS, 8'd5, 8'h55, 0, 0, 0, 2'd1, 8'h00, 3'd4);
    run("t4_rd2",  CMD_RD,  8'd2, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd4);
    run("t4_rd5",  CMD_RD,  8'd5, 8'h00, 1, 0, 0, 2'd1, 8'h55, 3'd4);
`else
    run("t3_ins5", CMD_INS, 8'd5, 8'h55, 0, 0, 1, 2'd0, 8'h00, 3'd4);
    run("t3_rd5",  CMD_RD,  8'd5, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd4);
    run("t3_rd1",  CMD_RD,  8'd1, 8'h00, 1, 0, 0, 2'd0, 8'h11, 3'd4);
`endif

    // 5: delete frees a slot that the next insert reuses; deleting an absent key is a no-op.
    do_reset();
    fill4();
    run("t5_del3", CMD_DEL, 8'd3, 8'h00, 1, 0, 0, 2'd2, 8'h00, 3'd3);
    run("t5_rd3",  CMD_RD,  8'd3, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd3);
    run("t5_ins9", CMD_INS, 8'd9, 8'h99, 0, 0, 0, 2'd2, 8'h00, 3'd4);
    run("t5_del7", CMD_DEL, 8'd7, 8'h00, 0, 0, 0, 2'd0, 8'h00, 3'd4);
    run("t5_rd9",  CMD_RD,  8'd9, 8'h00, 1, 0, 0, 2'd2, 8'h99, 3'd4);
    run("t5_rd4",  CMD_RD,  8'd4, 8'h00, 1, 0, 0, 2'd3, 8'h44, 3'd4);

    // 6: reset during LOOKUP abandons the command.
    do_reset();
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd = CMD_INS; bus.key = 8'h20; bus.datain = 8'h77;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_occ", 32'(bus.occupancy), 32'd0);
    check("t6_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t6_no_rsp2", 32'(bus.rsp_valid), 32'd0);
    run("t6_rd", CMD_RD, 8'h20, 8'h00, 0, 1, 0, 2'd0, 8'h00, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
